// File: rtl/worldmap_portb_arbiter.sv
// Port B sharing between the VGA scaler path and a blanking-only CPU reader.
// Video owns the BRAM during active display; CPU reads retry until a guarded blank slot.
module worldmap_portb_arbiter #(
   parameter int AW      = 14,
   parameter int DW      = 2,
   parameter int RD_LAT  = 1,
   parameter int GUARD   = 2,
   parameter int TIMEOUT = 4096
) (
   input  logic          clk_in,
   input  logic          reset_n,
   input  logic          video_on,
   input  logic [AW-1:0] vid_addr,
   output logic [DW-1:0] vid_pixel,
   input  logic          cpu_req,
   input  logic [AW-1:0] cpu_addr,
   output logic          cpu_busy,
   output logic          cpu_ack,
   output logic          cpu_err,
   output logic [DW-1:0] cpu_data,
   output logic [AW-1:0] ram_addr,
   input  logic [DW-1:0] ram_data
);

   localparam int WCW = $clog2(TIMEOUT + 1);
   localparam int GCW = $clog2(GUARD + 2);
   localparam int LCW = $clog2(RD_LAT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ISSUE,
      S_READ
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
   logic [LCW-1:0]  lat_cnt_q, lat_cnt_d;
   logic [GCW-1:0]  blank_cnt_q, blank_cnt_d;
   logic            busy_q, busy_d;
   logic            ack_q, ack_d;
   logic            err_q, err_d;
   logic [DW-1:0]   data_q, data_d;
   logic            slot_ok;
   logic            own_port;

   assign slot_ok   = (blank_cnt_q >= GCW'(GUARD)) && !video_on;
   assign own_port  = (state_q == S_ISSUE) || (state_q == S_READ);
   assign ram_addr  = own_port ? addr_q : vid_addr;
   assign vid_pixel = ram_data;
   assign cpu_busy  = busy_q;
   assign cpu_ack   = ack_q;
   assign cpu_err   = err_q;
   assign cpu_data  = data_q;

   always_comb begin
      blank_cnt_d = blank_cnt_q;
      if (video_on) begin
         blank_cnt_d = '0;
      end else if (blank_cnt_q != GCW'(GUARD)) begin
         blank_cnt_d = blank_cnt_q + 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wait_cnt_d = wait_cnt_q;
      lat_cnt_d  = lat_cnt_q;
      busy_d     = busy_q;
      ack_d      = 1'b0;
      err_d      = 1'b0;
      data_d     = data_q;
      unique case (state_q)
         S_IDLE: begin
            if (cpu_req) begin
               addr_d     = cpu_addr;
               wait_cnt_d = '0;
               busy_d     = 1'b1;
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            // saturate so an abort late in the window still times out
            if (wait_cnt_q != WCW'(TIMEOUT)) begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
            if (slot_ok) begin
               state_d = S_ISSUE;
            end else if (wait_cnt_q >= WCW'(TIMEOUT - 1)) begin
               ack_d   = 1'b1;
               err_d   = 1'b1;
               data_d  = '0;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            if (video_on) begin
               state_d = S_WAIT;
            end else begin
               lat_cnt_d = '0;
               state_d   = S_READ;
            end
         end
         S_READ: begin
            if (video_on) begin
               state_d = S_WAIT;
            end else if (lat_cnt_q == LCW'(RD_LAT - 1)) begin
               data_d  = ram_data;
               ack_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               lat_cnt_d = lat_cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         wait_cnt_q  <= '0;
         lat_cnt_q   <= '0;
         blank_cnt_q <= '0;
         busy_q      <= 1'b0;
         ack_q       <= 1'b0;
         err_q       <= 1'b0;
         data_q      <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wait_cnt_q  <= wait_cnt_d;
         lat_cnt_q   <= lat_cnt_d;
         blank_cnt_q <= blank_cnt_d;
         busy_q      <= busy_d;
         ack_q       <= ack_d;
         err_q       <= err_d;
         data_q      <= data_d;
      end
   end

endmodule
